// File: rtl/traffic_light_controller_nway_pkg.sv
// Shared phase encoding for the N-way traffic light controller.
// Code 2'd3 is never produced and is decoded as all-red.
package traffic_light_controller_nway_pkg;

    typedef enum logic [1:0] {
        PH_GREEN   = 2'd0,
        PH_YELLOW  = 2'd1,
        PH_ALL_RED = 2'd2
    } phase_e;

endpackage

// File: rtl/traffic_light_controller_nway_rr_next_way.sv
// Round-robin way picker: first requesting way after cur_way, wrapping, with cur_way itself last.
// With no requests next_way echoes cur_way and any_req is low.
module rr_next_way #(
    parameter int NUM_WAYS = 4,
    parameter int WW       = $clog2(NUM_WAYS)
) (
    input  logic [NUM_WAYS-1:0] req,
    input  logic [WW-1:0]       cur_way,
    output logic [WW-1:0]       next_way,
    output logic                any_req
);

    always_comb begin
        next_way = cur_way;
        any_req  = 1'b0;
        for (int i = 1; i <= NUM_WAYS; i++) begin
            if (!any_req && req[(int'(cur_way) + i) % NUM_WAYS]) begin
                next_way = WW'((int'(cur_way) + i) % NUM_WAYS);
                any_req  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/traffic_light_controller_nway.sv
// N-way sensor-driven round-robin traffic light controller with min/max green,
// yellow and all-red clearance timing plus emergency preemption.
module traffic_light_controller_nway
    import traffic_light_controller_nway_pkg::*;
#(
    parameter  int NUM_WAYS    = 4,
    parameter  int MIN_GREEN   = 8,
    parameter  int MAX_GREEN   = 32,
    parameter  int YELLOW_CYC  = 3,
    parameter  int ALL_RED_CYC = 2,
    localparam int WW          = $clog2(NUM_WAYS),
    localparam int TW          = $clog2(MAX_GREEN + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_WAYS-1:0] t,
    input  logic                preempt_req,
    input  logic [WW-1:0]       preempt_way,
    output logic [NUM_WAYS-1:0] red,
    output logic [NUM_WAYS-1:0] yellow,
    output logic [NUM_WAYS-1:0] green,
    output logic [1:0]          phase,
    output logic [WW-1:0]       active_way
);

    phase_e              phase_q, phase_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [WW-1:0]       way_q, way_d;
    logic                fresh_q, fresh_d;
    logic [NUM_WAYS-1:0] red_q, red_d;
    logic [NUM_WAYS-1:0] yellow_q, yellow_d;
    logic [NUM_WAYS-1:0] green_q, green_d;

    logic                preempt_valid;
    logic [NUM_WAYS-1:0] way_sel;
    logic                yield;
    logic [WW-1:0]       rr_next;
    logic                rr_any;

    assign preempt_valid = preempt_req && (int'(preempt_way) < NUM_WAYS);
    assign way_sel       = NUM_WAYS'(1) << way_q;
    assign yield         = |(t & ~way_sel);

    rr_next_way #(
        .NUM_WAYS (NUM_WAYS),
        .WW       (WW)
    ) u_rr (
        .req      (t),
        .cur_way  (way_q),
        .next_way (rr_next),
        .any_req  (rr_any)
    );

    // fresh_q marks the first all-red after reset, where an idle intersection starts on way 0.
    always_comb begin
        phase_d = phase_q;
        way_d   = way_q;
        fresh_d = fresh_q;
        timer_d = (timer_q == TW'(MAX_GREEN)) ? timer_q : timer_q + TW'(1);

        case (phase_q)
            PH_GREEN: begin
                if (preempt_valid) begin
                    if (preempt_way != way_q) begin
                        phase_d = PH_YELLOW;
                        timer_d = '0;
                    end
                end else if (yield && timer_q >= TW'(MIN_GREEN - 1) &&
                             (!t[way_q] || timer_q >= TW'(MAX_GREEN - 1))) begin
                    phase_d = PH_YELLOW;
                    timer_d = '0;
                end
            end
            PH_YELLOW: begin
                if (timer_q == TW'(YELLOW_CYC - 1)) begin
                    phase_d = PH_ALL_RED;
                    timer_d = '0;
                end
            end
            default: begin
                if (timer_q == TW'(ALL_RED_CYC - 1)) begin
                    phase_d = PH_GREEN;
                    timer_d = '0;
                    fresh_d = 1'b0;
                    if (preempt_valid) begin
                        way_d = preempt_way;
                    end else if (rr_any) begin
                        way_d = rr_next;
                    end else if (fresh_q) begin
                        way_d = '0;
                    end
                end
            end
        endcase
    end

    // Lamps follow the next state so they change on the same edge as the phase register.
    always_comb begin
        red_d    = '1;
        yellow_d = '0;
        green_d  = '0;
        if (phase_d == PH_GREEN) begin
            green_d[way_d] = 1'b1;
            red_d[way_d]   = 1'b0;
        end else if (phase_d == PH_YELLOW) begin
            yellow_d[way_d] = 1'b1;
            red_d[way_d]    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q  <= PH_ALL_RED;
            timer_q  <= '0;
            way_q    <= WW'(NUM_WAYS - 1);
            fresh_q  <= 1'b1;
            red_q    <= '1;
            yellow_q <= '0;
            green_q  <= '0;
        end else begin
            phase_q  <= phase_d;
            timer_q  <= timer_d;
            way_q    <= way_d;
            fresh_q  <= fresh_d;
            red_q    <= red_d;
            yellow_q <= yellow_d;
            green_q  <= green_d;
        end
    end

    assign red        = red_q;
    assign yellow     = yellow_q;
    assign green      = green_q;
    assign phase      = phase_q;
    assign active_way = way_q;

endmodule

// File: tb/tb_traffic_light_controller_nway.sv
// Scoreboard bench for traffic_light_controller_nway: a cycle-count reference model predicts
// each post-edge output, a monitor process compares it and the lamp invariants every cycle.
module tb_traffic_light_controller_nway;

    localparam int N    = 4;
    localparam int MING = 8;
    localparam int MAXG = 32;
    localparam int YC   = 3;
    localparam int ARC  = 2;
    localparam int WW   = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  t;
    logic          preempt_req;
    logic [WW-1:0] preempt_way;
    logic [N-1:0]  red, yellow, green;
    logic [1:0]    phase;
    logic [WW-1:0] active_way;

    traffic_light_controller_nway dut (
        .clk         (clk),
        .rst         (rst),
        .t           (t),
        .preempt_req (preempt_req),
        .preempt_way (preempt_way),
        .red         (red),
        .yellow      (yellow),
        .green       (green),
        .phase       (phase),
        .active_way  (active_way)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]  r;
        logic [N-1:0]  y;
        logic [N-1:0]  g;
        logic [1:0]    ph;
        logic [WW-1:0] way;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: phase as 0=green 1=yellow 2=all-red, age = cycles already spent in phase.
    int   m_phase;
    int   m_way;
    int   m_age;
    bit   m_fresh;

    task automatic modelReset();
        m_phase = 2;
        m_way   = N - 1;
        m_age   = 0;
        m_fresh = 1'b1;
    endtask

    function automatic exp_t modelView();
        exp_t e;
        e.r   = '1;
        e.y   = '0;
        e.g   = '0;
        e.ph  = 2'(m_phase);
        e.way = WW'(m_way);
        if (m_phase == 0) begin
            e.g[m_way] = 1'b1;
            e.r[m_way] = 1'b0;
        end else if (m_phase == 1) begin
            e.y[m_way] = 1'b1;
            e.r[m_way] = 1'b0;
        end
        return e;
    endfunction

    task automatic modelStep(input logic [N-1:0] tv, input bit pr, input int pw);
        bit pv;
        bit others;
        bit leave;
        bit found;
        int nxt;
        int served;
        pv     = pr && (pw < N);
        others = 1'b0;
        leave  = 1'b0;
        served = m_age + 1;
        if (m_phase == 0) begin
            for (int j = 0; j < N; j++)
                if (j != m_way && tv[j]) others = 1'b1;
            if (pv) leave = (pw != m_way);
            else    leave = others && served >= MING && (!tv[m_way] || served >= MAXG);
            if (leave) begin
                m_phase = 1;
                m_age   = 0;
            end else begin
                m_age++;
            end
        end else if (m_phase == 1) begin
            if (served == YC) begin
                m_phase = 2;
                m_age   = 0;
            end else begin
                m_age++;
            end
        end else begin
            if (served == ARC) begin
                nxt   = m_fresh ? 0 : m_way;
                found = 1'b0;
                for (int k = 1; k <= N; k++) begin
                    if (!found && tv[(m_way + k) % N]) begin
                        nxt   = (m_way + k) % N;
                        found = 1'b1;
                    end
                end
                if (pv) nxt = pw;
                m_way   = nxt;
                m_phase = 0;
                m_age   = 0;
                m_fresh = 1'b0;
            end else begin
                m_age++;
            end
        end
    endtask

    task automatic checkOutput(input string name, input exp_t e);
        checks++;
        if (red !== e.r || yellow !== e.y || green !== e.g || phase !== e.ph || active_way !== e.way) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got r=%b y=%b g=%b ph=%0d way=%0d, want r=%b y=%b g=%b ph=%0d way=%0d",
                     name, $time, red, yellow, green, phase, active_way,
                     e.r, e.y, e.g, e.ph, e.way);
        end
    endtask

    task automatic checkInvariants();
        int nonred;
        bit bad;
        nonred = 0;
        bad    = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (int'(red[i]) + int'(yellow[i]) + int'(green[i]) != 1) bad = 1'b1;
            if (!red[i]) nonred++;
        end
        checks++;
        if (bad || nonred > 1) begin
            errors++;
            $display("[TB] FAIL invariant at %0t: got r=%b y=%b g=%b, want one lamp per way and at most one non-red",
                     $time, red, yellow, green);
        end
    endtask

    task automatic stepNow(input logic [N-1:0] tv, input bit pr, input int pw);
        t           = tv;
        preempt_req = pr;
        preempt_way = WW'(pw);
        modelStep(tv, pr, pw);
        sb.push_back(modelView());
    endtask

    task automatic applyStimulus(input logic [N-1:0] tv, input bit pr, input int pw);
        @(negedge clk);
        #1;
        stepNow(tv, pr, pw);
    endtask

    // Monitor: every negedge the oldest prediction is due, since it was queued before the posedge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput("cycle", e);
                checkInvariants();
            end
        end
    end

    initial begin
        int  pr_left;
        int  pw_hold;
        bit  hit;
        logic [N-1:0] tv;

        rst         = 1'b1;
        t           = '0;
        preempt_req = 1'b0;
        preempt_way = '0;
        modelReset();
        repeat (2) @(negedge clk);
        checkOutput("reset", modelView());

        @(negedge clk);
        #1;
        rst = 1'b0;
        stepNow(4'b0000, 1'b0, 0);
        repeat (4) applyStimulus(4'b0000, 1'b0, 0);

        repeat (2) applyStimulus(4'b0001, 1'b0, 0);
        repeat (20) applyStimulus(4'b0100, 1'b0, 0);
        repeat (12) applyStimulus(4'b0001, 1'b0, 0);
        repeat (80) applyStimulus(4'b0011, 1'b0, 0);
        repeat (80) applyStimulus(4'b1111, 1'b0, 0);
        repeat (80) applyStimulus(4'b1111, 1'b1, 3);
        repeat (20) applyStimulus(4'b1111, 1'b0, 0);

        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            applyStimulus(4'b1111, 1'b0, 0);
            if (m_phase == 1) hit = 1'b1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("[TB] FAIL reach_yellow: got no yellow within 200 cycles, want a yellow phase");
        end
        @(negedge clk);
        #2;
        rst = 1'b1;
        modelReset();
        #1;
        checkOutput("async_reset", modelView());
        @(negedge clk);
        checkOutput("reset_hold", modelView());
        #1;
        rst = 1'b0;
        stepNow(4'b0000, 1'b0, 0);

        pr_left = 0;
        pw_hold = 0;
        for (int c = 0; c < 2000; c++) begin
            tv = N'($urandom);
            if ($urandom_range(0, 3) == 0) tv = tv & N'($urandom);
            if (pr_left > 0) begin
                pr_left--;
            end else if ($urandom_range(0, 39) == 0) begin
                pr_left = $urandom_range(1, 50);
                pw_hold = $urandom_range(0, N - 1);
            end
            applyStimulus(tv, pr_left > 0, pw_hold);
        end

        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending, want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
